time_set_ctrl: RTL and testbench

Front-panel controller for the `time_float` calendar-clock datapath. It debounces the four panel keys and runs a RUN/SET mode machine. It produces `time_float`'s `adjust`, `select`, `add` and `clr` controls, with clean, bounded-width pulses and auto-repeat. It sits between the top-level key inversion and `time_float`, and drives a blink enable for the display block.

---
 rtl/time_ctrl_pkg.sv | 19 +
 rtl/key_debounce.sv | 56 +++++
 rtl/time_set_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_ctrl_pkg.sv
// Shared types and constants for the front-panel time-set controller.
package time_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Field indices in the datapath encoding; 0/1 are the millisecond fields.
    localparam logic [3:0] SEL_FIRST = 4'd2;
    localparam logic [3:0] SEL_LAST  = 4'd15;

    // Advance the selected field, wrapping from the last back to the first.
    function automatic logic [3:0] next_sel(input logic [3:0] sel);
        return (sel == SEL_LAST) ? SEL_FIRST : sel + 4'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: the level follows the raw key after DEB_CYC equal
// samples; press is a one-cycle pulse one cycle after the level rises.
// The raw key is expected to be synchronous to CLOCK_50 already.
module key_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q, press_d;

    // Count consecutive samples that differ from the current level.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d   = '0;
        level_d = level_q;
        press_d = level_q & ~level_dly_q;
        if (raw != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = raw;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel controller for time_float: debounced keys, RUN/SET/DRAIN mode
// machine, bounded add/clr pulse engine, auto-repeat, SET timeout and blink.
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int DEB_CYC    = 1_000_000,
    parameter int PULSE_W    = 4,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000,
    parameter int TIMEOUT    = 1_500_000_000,
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_next,
    input  logic       key_add,
    input  logic       key_clr,
    output logic       adjust,
    output logic [3:0] select,
    output logic       add,
    output logic       clr,
    output logic       blink_on
);

    // Pulse counter holds the remaining busy cycles: PULSE_W high, PULSE_W guard.
    localparam int PCW   = $clog2(2 * PULSE_W);
    localparam int REP_W = $clog2(REP_DELAY + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [PCW-1:0]   PCNT_START = PCW'(2 * PULSE_W - 1);
    localparam logic [PCW-1:0]   PCNT_HIGH  = PCW'(PULSE_W);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REP_DELAY);
    // Reloading here makes the next fire exactly REP_PERIOD cycles later.
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_PERIOD + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(TIMEOUT - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_HALF - 1);

    logic       press_mode, press_next, press_add, press_clr;
    logic       level_add;
    logic [2:0] unused_levels;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
        .CLOCK_50(CLOCK_50), .rst(rst), .raw(key_mode),
        .level(unused_levels[0]), .press(press_mode)
    );
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
        .CLOCK_50(CLOCK_50), .rst(rst), .raw(key_next),
        .level(unused_levels[1]), .press(press_next)
    );
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_add (
        .CLOCK_50(CLOCK_50), .rst(rst), .raw(key_add),
        .level(level_add), .press(press_add)
    );
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (
        .CLOCK_50(CLOCK_50), .rst(rst), .raw(key_clr),
        .level(unused_levels[2]), .press(press_clr)
    );

    state_e           state_q, state_d;
    logic             adjust_q, adjust_d;
    logic [3:0]       select_q, select_d;
    logic             add_q, add_d;
    logic             clr_q, clr_d;
    logic             blink_q, blink_d;
    logic [PCW-1:0]   pcnt_q, pcnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [BLK_W-1:0] blk_q, blk_d;

    logic pe_idle;
    logic rep_evt;
    logic any_evt;

    // Next-state logic for the mode machine, pulse engine and all counters.
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        add_d    = add_q;
        clr_d    = clr_q;
        pcnt_d   = pcnt_q;
        rep_d    = rep_q;
        tmo_d    = tmo_q;
        blink_d  = blink_q;
        blk_d    = blk_q;

        pe_idle = (pcnt_q == '0);
        rep_evt = (state_q == SET) && level_add && (rep_q == REP_FIRE);
        any_evt = press_mode | press_next | press_add | press_clr | rep_evt;

        unique case (state_q)
            RUN: begin
                if (press_mode) begin
                    state_d  = SET;
                    select_d = SEL_FIRST;
                end
            end
            SET: begin
                if (press_mode || (tmo_q == '0)) state_d = DRAIN;
                if (press_next) select_d = next_sel(select_q);
            end
            DRAIN: begin
                // Hold adjust low until add/clr and its guard are both over.
                if (pe_idle) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        adjust_d = (state_d == RUN);

        // Pulse engine: events while busy are dropped; clr beats add.
        if (!pe_idle) begin
            pcnt_d = pcnt_q - PCW'(1);
            if (pcnt_q <= PCNT_HIGH) begin
                add_d = 1'b0;
                clr_d = 1'b0;
            end
        end else if (state_q == SET) begin
            if (press_clr) begin
                clr_d  = 1'b1;
                pcnt_d = PCNT_START;
            end else if (press_add || rep_evt) begin
                add_d  = 1'b1;
                pcnt_d = PCNT_START;
            end
        end

        // Auto-repeat hold counter, live only while add is held in SET.
        if (!((state_q == SET) && level_add)) begin
            rep_d = '0;
        end else if (press_add) begin
            rep_d = REP_W'(1);
        end else if (rep_q == REP_FIRE) begin
            rep_d = REP_RELOAD;
        end else if (rep_q != '0) begin
            rep_d = rep_q + REP_W'(1);
        end

        // Idle timeout: reload on SET entry and on every event in SET.
        if ((state_q == RUN) && (state_d == SET)) begin
            tmo_d = TMO_LOAD;
        end else if (state_q == SET) begin
            if (any_evt) tmo_d = TMO_LOAD;
            else if (tmo_q != '0) tmo_d = tmo_q - TMO_W'(1);
        end

        // Blink: off in RUN, restarted high on entry or field change, frozen in DRAIN.
        if (state_d == RUN) begin
            blink_d = 1'b0;
            blk_d   = '0;
        end else if ((state_q == RUN) || (select_d != select_q)) begin
            blink_d = 1'b1;
            blk_d   = '0;
        end else if (state_q == SET) begin
            if (blk_q == BLK_LAST) begin
                blink_d = ~blink_q;
                blk_d   = '0;
            end else begin
                blk_d = blk_q + BLK_W'(1);
            end
        end
    end

    // Register all state and outputs; reset acts immediately.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            adjust_q <= 1'b1;
            select_q <= 4'd0;
            add_q    <= 1'b0;
            clr_q    <= 1'b0;
            blink_q  <= 1'b0;
            pcnt_q   <= '0;
            rep_q    <= '0;
            tmo_q    <= '0;
            blk_q    <= '0;
        end else begin
            state_q  <= state_d;
            adjust_q <= adjust_d;
            select_q <= select_d;
            add_q    <= add_d;
            clr_q    <= clr_d;
            blink_q  <= blink_d;
            pcnt_q   <= pcnt_d;
            rep_q    <= rep_d;
            tmo_q    <= tmo_d;
            blk_q    <= blk_d;
        end
    end

    assign adjust   = adjust_q;
    assign select   = select_q;
    assign add      = add_q;
    assign clr      = clr_q;
    assign blink_on = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short timing parameters.
module tb_time_set_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       rst;
    logic       key_mode, key_next, key_add, key_clr;
    logic       adjust, add, clr, blink_on;
    logic [3:0] select;

    int checks   = 0;
    int failures = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    time_set_ctrl #(
        .DEB_CYC(4), .PULSE_W(2), .REP_DELAY(20), .REP_PERIOD(8),
        .TIMEOUT(100), .BLINK_HALF(10)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst),
        .key_mode(key_mode), .key_next(key_next), .key_add(key_add), .key_clr(key_clr),
        .adjust(adjust), .select(select), .add(add), .clr(clr), .blink_on(blink_on)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        rst = 1'b1; key_mode = 1'b0; key_next = 1'b0; key_add = 1'b0; key_clr = 1'b0;
        tick(2);
        checks++; if (adjust !== 1'b1) begin failures++; $display("FAIL reset_adjust got=%b exp=1", adjust); end
        checks++; if (select !== 4'd0) begin failures++; $display("FAIL reset_select got=%0d exp=0", select); end
        checks++; if (add !== 1'b0) begin failures++; $display("FAIL reset_add got=%b exp=0", add); end
        checks++; if (clr !== 1'b0) begin failures++; $display("FAIL reset_clr got=%b exp=0", clr); end
        checks++; if (blink_on !== 1'b0) begin failures++; $display("FAIL reset_blink got=%b exp=0", blink_on); end
        rst = 1'b0;
        tick(3);
        checks++; if (adjust !== 1'b1) begin failures++; $display("FAIL idle_run_adjust got=%b exp=1", adjust); end
    endtask

    task automatic test_bounce();
        int   falls = 0;
        logic prev  = adjust;
        for (int i = 0; i < 6; i++) begin
            key_mode = (i % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                tick(1);
                if (prev && !adjust) falls++;
                prev = adjust;
            end
        end
        checks++; if (adjust !== 1'b1) begin failures++; $display("FAIL bounce_no_entry got=%b exp=1", adjust); end
        key_mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (prev && !adjust) falls++;
            prev = adjust;
        end
        checks++; if (adjust !== 1'b1) begin failures++; $display("FAIL settle_adjust_c5 got=%b exp=1", adjust); end
        tick(1);
        if (prev && !adjust) falls++;
        prev = adjust;
        checks++; if (adjust !== 1'b0) begin failures++; $display("FAIL settle_adjust_c6 got=%b exp=0", adjust); end
        checks++; if (select !== 4'd2) begin failures++; $display("FAIL entry_select got=%0d exp=2", select); end
        checks++; if (blink_on !== 1'b1) begin failures++; $display("FAIL entry_blink got=%b exp=1", blink_on); end
        key_mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (prev && !adjust) falls++;
            prev = adjust;
        end
        checks++; if (falls != 1) begin failures++; $display("FAIL set_entries got=%0d exp=1", falls); end
        checks++; if (adjust !== 1'b0) begin failures++; $display("FAIL still_set got=%b exp=0", adjust); end
    endtask

    task automatic test_field_wrap();
        logic [3:0] exp_sel = 4'd2;
        for (int i = 0; i < 14; i++) begin
            exp_sel = (exp_sel == 4'd15) ? 4'd2 : exp_sel + 4'd1;
            key_next = 1'b1;
            tick(6);
            checks++; if (select !== exp_sel) begin failures++; $display("FAIL wrap_select[%0d] got=%0d exp=%0d", i, select, exp_sel); end
            checks++; if (blink_on !== 1'b1) begin failures++; $display("FAIL wrap_blink[%0d] got=%b exp=1", i, blink_on); end
            key_next = 1'b0;
            tick(6);
        end
    endtask

    task automatic test_auto_repeat();
        int   exp_off[6] = '{0, 20, 28, 36, 44, 52};
        int   rise_t[$];
        int   widths[$];
        int   run     = 0;
        logic prev    = 1'b0;
        bit   overlap = 1'b0;
        bit   clr_hit = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (t == 0)  key_add = 1'b1;
            if (t == 60) key_add = 1'b0;
            tick(1);
            if (add && !prev) rise_t.push_back(t);
            if (add) run++;
            else if (prev) begin widths.push_back(run); run = 0; end
            if (add && adjust) overlap = 1'b1;
            if (clr) clr_hit = 1'b1;
            prev = add;
        end
        checks++; if (rise_t.size() != 6) begin failures++; $display("FAIL repeat_count got=%0d exp=6", rise_t.size()); end
        if (rise_t.size() > 0) begin
            checks++; if (rise_t[0] != 5) begin failures++; $display("FAIL first_add_latency got=%0d exp=5", rise_t[0]); end
        end
        for (int i = 0; i < 6 && i < rise_t.size(); i++) begin
            checks++;
            if (rise_t[i] - rise_t[0] != exp_off[i]) begin
                failures++; $display("FAIL repeat_offset[%0d] got=%0d exp=%0d", i, rise_t[i] - rise_t[0], exp_off[i]);
            end
        end
        checks++; if (widths.size() != 6) begin failures++; $display("FAIL repeat_pulses_ended got=%0d exp=6", widths.size()); end
        for (int i = 0; i < widths.size(); i++) begin
            checks++; if (widths[i] != 2) begin failures++; $display("FAIL repeat_width[%0d] got=%0d exp=2", i, widths[i]); end
        end
        checks++; if (overlap) begin failures++; $display("FAIL repeat_adjust_overlap got=1 exp=0"); end
        checks++; if (clr_hit) begin failures++; $display("FAIL repeat_clr got=1 exp=0"); end
    endtask

    task automatic test_simultaneous();
        int add_cyc = 0;
        int clr_cyc = 0;
        bit both    = 1'b0;
        key_add = 1'b1; key_clr = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (t == 8) begin key_add = 1'b0; key_clr = 1'b0; end
            tick(1);
            if (add) add_cyc++;
            if (clr) clr_cyc++;
            if (add && clr) both = 1'b1;
        end
        checks++; if (clr_cyc != 2) begin failures++; $display("FAIL simul_clr_cycles got=%0d exp=2", clr_cyc); end
        checks++; if (add_cyc != 0) begin failures++; $display("FAIL simul_add_cycles got=%0d exp=0", add_cyc); end
        checks++; if (both) begin failures++; $display("FAIL simul_add_and_clr got=1 exp=0"); end
        tick(6);
    endtask

    task automatic test_drain();
        logic add_v[0:16];
        logic adj_v[0:16];
        logic blk_v[0:16];
        bit   overlap = 1'b0;
        key_mode = 1'b1; key_add = 1'b1;
        for (int t = 0; t < 16; t++) begin
            if (t == 8) begin key_mode = 1'b0; key_add = 1'b0; end
            tick(1);
            add_v[t + 1] = add; adj_v[t + 1] = adjust; blk_v[t + 1] = blink_on;
            if (add && adjust) overlap = 1'b1;
        end
        checks++; if (add_v[6] !== 1'b1) begin failures++; $display("FAIL drain_add_c6 got=%b exp=1", add_v[6]); end
        checks++; if (add_v[7] !== 1'b1) begin failures++; $display("FAIL drain_add_c7 got=%b exp=1", add_v[7]); end
        checks++; if (add_v[8] !== 1'b0) begin failures++; $display("FAIL drain_add_c8 got=%b exp=0", add_v[8]); end
        checks++; if (adj_v[6] !== 1'b0) begin failures++; $display("FAIL drain_adjust_c6 got=%b exp=0", adj_v[6]); end
        checks++; if (adj_v[9] !== 1'b0) begin failures++; $display("FAIL drain_adjust_c9 got=%b exp=0", adj_v[9]); end
        checks++; if (adj_v[10] !== 1'b1) begin failures++; $display("FAIL drain_adjust_c10 got=%b exp=1", adj_v[10]); end
        checks++; if (blk_v[10] !== 1'b0) begin failures++; $display("FAIL drain_run_blink got=%b exp=0", blk_v[10]); end
        checks++; if (overlap) begin failures++; $display("FAIL drain_overlap got=1 exp=0"); end
        tick(4);
    endtask

    task automatic test_timeout();
        logic adj_v[0:112];
        logic blk_v[0:112];
        key_mode = 1'b1;
        for (int t = 0; t < 112; t++) begin
            if (t == 10) key_mode = 1'b0;
            tick(1);
            adj_v[t + 1] = adjust; blk_v[t + 1] = blink_on;
        end
        checks++; if (adj_v[6] !== 1'b0) begin failures++; $display("FAIL tmo_entry got=%b exp=0", adj_v[6]); end
        checks++; if (blk_v[15] !== 1'b1) begin failures++; $display("FAIL blink_c15 got=%b exp=1", blk_v[15]); end
        checks++; if (blk_v[16] !== 1'b0) begin failures++; $display("FAIL blink_c16 got=%b exp=0", blk_v[16]); end
        checks++; if (blk_v[26] !== 1'b1) begin failures++; $display("FAIL blink_c26 got=%b exp=1", blk_v[26]); end
        checks++; if (adj_v[106] !== 1'b0) begin failures++; $display("FAIL tmo_adjust_c106 got=%b exp=0", adj_v[106]); end
        checks++; if (adj_v[107] !== 1'b1) begin failures++; $display("FAIL tmo_adjust_c107 got=%b exp=1", adj_v[107]); end
        checks++; if (blk_v[107] !== 1'b0) begin failures++; $display("FAIL tmo_blink got=%b exp=0", blk_v[107]); end
    endtask

    task automatic test_reset_mid_pulse();
        key_mode = 1'b1;
        tick(6);
        checks++; if (adjust !== 1'b0) begin failures++; $display("FAIL rmp_entry got=%b exp=0", adjust); end
        key_mode = 1'b0;
        tick(6);
        key_add = 1'b1;
        tick(6);
        checks++; if (add !== 1'b1) begin failures++; $display("FAIL rmp_pulse got=%b exp=1", add); end
        #2 rst = 1'b1;
        #1;
        checks++; if (add !== 1'b0) begin failures++; $display("FAIL rmp_add got=%b exp=0", add); end
        checks++; if (adjust !== 1'b1) begin failures++; $display("FAIL rmp_adjust got=%b exp=1", adjust); end
        checks++; if (select !== 4'd0) begin failures++; $display("FAIL rmp_select got=%0d exp=0", select); end
        checks++; if (blink_on !== 1'b0) begin failures++; $display("FAIL rmp_blink got=%b exp=0", blink_on); end
        key_add = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(8);
        checks++; if (adjust !== 1'b1) begin failures++; $display("FAIL post_reset_adjust got=%b exp=1", adjust); end
        checks++; if (add !== 1'b0) begin failures++; $display("FAIL post_reset_add got=%b exp=0", add); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_field_wrap();
        test_auto_repeat();
        test_simultaneous();
        test_drain();
        test_timeout();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
